// File: rtl/key_conditioner.sv
// Pushbutton conditioner: per-key 2-flop synchroniser, debounce, press/release pulses
// and an auto-repeat step generator used to single-step the pipeline from a held key.
module key_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic [NUM_KEYS-1:0] repeat_en,
  output logic [NUM_KEYS-1:0] level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] step
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX) + 1;

  localparam logic [DW-1:0] DTERM      = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_TERM = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_TERM  = RW'(REPEAT_RATE - 1);
  localparam logic [NUM_KEYS-1:0] RELEASED =
    (ACTIVE_LOW != 0) ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};

  typedef enum logic [1:0] {IDLE, HELD, DELAY, REPEAT} rstate_e;

  logic [NUM_KEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_KEYS-1:0] level_q, level_d, press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d, step_q, step_d;
  logic [NUM_KEYS-1:0] ren_q, ren_d;
  logic [DW-1:0]       dcnt_q  [NUM_KEYS];
  logic [DW-1:0]       dcnt_d  [NUM_KEYS];
  logic [RW-1:0]       rcnt_q  [NUM_KEYS];
  logic [RW-1:0]       rcnt_d  [NUM_KEYS];
  rstate_e             state_q [NUM_KEYS];
  rstate_e             state_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] pressed_s;
  logic [NUM_KEYS-1:0] toggle_s;

  // XOR with the released pattern normalises polarity so 1 always means pressed.
  assign pressed_s = sync2_q ^ RELEASED;

  always_comb begin
    sync1_d   = key_raw;
    sync2_d   = sync1_q;
    ren_d     = repeat_en;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    step_d    = '0;
    toggle_s  = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      dcnt_d[k]  = '0;
      rcnt_d[k]  = rcnt_q[k];
      state_d[k] = state_q[k];

      if (pressed_s[k] != level_q[k]) begin
        if (dcnt_q[k] == DTERM) begin
          toggle_s[k] = 1'b1;
          level_d[k]  = ~level_q[k];
        end else begin
          dcnt_d[k] = dcnt_q[k] + DW'(1);
        end
      end else begin
        dcnt_d[k] = '0;
      end
      press_d[k]   = toggle_s[k] & ~level_q[k];
      release_d[k] = toggle_s[k] &  level_q[k];

      case (state_q[k])
        IDLE: begin
          if (press_d[k]) begin
            step_d[k]  = 1'b1;
            rcnt_d[k]  = '0;
            state_d[k] = repeat_en[k] ? DELAY : HELD;
          end else begin
            rcnt_d[k] = '0;
          end
        end
        HELD: begin
          if (release_d[k]) begin
            state_d[k] = IDLE;
            rcnt_d[k]  = '0;
          end else if (repeat_en[k] && !ren_q[k]) begin
            // The rising cycle itself counts as delay cycle zero.
            if (DELAY_TERM == '0) begin
              step_d[k]  = 1'b1;
              rcnt_d[k]  = '0;
              state_d[k] = REPEAT;
            end else begin
              rcnt_d[k]  = RW'(1);
              state_d[k] = DELAY;
            end
          end else begin
            rcnt_d[k] = '0;
          end
        end
        DELAY, REPEAT: begin
          if (release_d[k]) begin
            state_d[k] = IDLE;
            rcnt_d[k]  = '0;
          end else if (!repeat_en[k]) begin
            state_d[k] = HELD;
            rcnt_d[k]  = '0;
          end else if (rcnt_q[k] == ((state_q[k] == DELAY) ? DELAY_TERM : RATE_TERM)) begin
            step_d[k]  = 1'b1;
            rcnt_d[k]  = '0;
            state_d[k] = REPEAT;
          end else if (rcnt_q[k] != '1) begin
            rcnt_d[k] = rcnt_q[k] + RW'(1);
          end else begin
            rcnt_d[k] = rcnt_q[k];
          end
        end
        default: begin
          state_d[k] = IDLE;
          rcnt_d[k]  = '0;
        end
      endcase
    end
  end

  // State register; synchronisers reload the released value so held keys re-qualify.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= RELEASED;
      sync2_q   <= RELEASED;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      step_q    <= '0;
      ren_q     <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        dcnt_q[k]  <= '0;
        rcnt_q[k]  <= '0;
        state_q[k] <= IDLE;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      step_q    <= step_d;
      ren_q     <= ren_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        dcnt_q[k]  <= dcnt_d[k];
        rcnt_q[k]  <= rcnt_d[k];
        state_q[k] <= state_d[k];
      end
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign step          = step_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios with literal expectations plus random
// key activity, all compared every cycle against a cycle-scheduled behavioural model.
module tb_key_conditioner;

  localparam int NK = 4;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [NK-1:0] key_raw;
  logic [NK-1:0] repeat_en;
  logic [NK-1:0] level, press_pulse, release_pulse, step;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  now      = 0;
  bit  compare_on = 1'b0;

  key_conditioner #(
    .NUM_KEYS(NK), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clock(clock), .reset(reset), .key_raw(key_raw), .repeat_en(repeat_en),
    .level(level), .press_pulse(press_pulse), .release_pulse(release_pulse), .step(step)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected outputs for the next cycle are derived from the sampled key history:
  // a change is accepted after D consecutive differing synchronised samples, and
  // auto-repeat steps are kept as an absolute "next step cycle" schedule.
  logic [NK-1:0] m_sync1, m_sync2, m_en_prev;
  logic [NK-1:0] exp_level, exp_press, exp_release, exp_step;
  int            m_run   [NK];
  longint        m_sched [NK];
  longint        mcyc = 0;

  initial begin
    logic pr, lvl, tog, stp;
    forever begin
      @(negedge clock);
      if (compare_on) begin
        chk("cmp_level",   level,         exp_level);
        chk("cmp_press",   press_pulse,   exp_press);
        chk("cmp_release", release_pulse, exp_release);
        chk("cmp_step",    step,          exp_step);
      end
      if (reset) begin
        m_sync1 = '1; m_sync2 = '1; m_en_prev = '0;
        exp_level = '0; exp_press = '0; exp_release = '0; exp_step = '0;
        for (int k = 0; k < NK; k++) begin
          m_run[k] = 0; m_sched[k] = -1;
        end
      end else begin
        for (int k = 0; k < NK; k++) begin
          lvl = exp_level[k];
          pr  = ~m_sync2[k];
          tog = 1'b0;
          stp = 1'b0;
          if (pr != lvl) begin
            m_run[k]++;
            if (m_run[k] == D) begin
              tog = 1'b1; m_run[k] = 0;
            end
          end else begin
            m_run[k] = 0;
          end
          exp_level[k]   = lvl ^ tog;
          exp_press[k]   = tog & ~lvl;
          exp_release[k] = tog & lvl;
          if (tog && !lvl) begin
            stp = 1'b1;
            m_sched[k] = repeat_en[k] ? mcyc + 1 + RD : -1;
          end else if (tog) begin
            m_sched[k] = -1;
          end else if (lvl) begin
            if (!repeat_en[k]) m_sched[k] = -1;
            else begin
              if (m_sched[k] < 0 && !m_en_prev[k]) m_sched[k] = mcyc + RD;
              if (m_sched[k] == mcyc + 1) begin
                stp = 1'b1; m_sched[k] = mcyc + 1 + RR;
              end
            end
          end
          exp_step[k] = stp;
        end
        m_sync2   = m_sync1;
        m_sync1   = key_raw;
        m_en_prev = repeat_en;
      end
      mcyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clock); #1; now++;
  endtask

  task automatic wait_until(input int t);
    while (now < t) next_cycle();
  endtask

  initial begin
    int c0;
    int hold_left [NK];
    reset = 1'b1; key_raw = '1; repeat_en = '0;
    repeat (3) next_cycle();
    reset = 1'b0; compare_on = 1'b1;
    next_cycle();
    chk("reset_level", level, 0);
    chk("reset_pulses", press_pulse | release_pulse | step, 0);
    chk("reset_model", exp_level | exp_step, 0);

    // 3-cycle glitch is filtered
    c0 = now; key_raw[0] = 1'b0;
    wait_until(c0 + 3); key_raw[0] = 1'b1;
    wait_until(c0 + 6); chk("glitch_level", level[0], 0);
    chk("glitch_press", press_pulse[0], 0);
    wait_until(c0 + 12);

    // press/release without repeat
    c0 = now; key_raw[0] = 1'b0;
    wait_until(c0 + 5); chk("p_level_pre", level[0], 0);
    wait_until(c0 + 6);
    chk("p_level", level[0], 1); chk("p_press", press_pulse[0], 1);
    chk("p_step", step[0], 1);   chk("p_model_press", exp_press[0], 1);
    wait_until(c0 + 7); chk("p_press_end", press_pulse[0], 0); chk("p_step_end", step[0], 0);
    wait_until(c0 + 20); key_raw[0] = 1'b1;
    wait_until(c0 + 25); chk("r_pre", release_pulse[0], 0);
    wait_until(c0 + 26);
    chk("r_pulse", release_pulse[0], 1); chk("r_nostep", step[0], 0);
    chk("r_level", level[0], 0); chk("r_model", exp_release[0], 1);
    wait_until(c0 + 27); chk("r_end", release_pulse[0], 0);
    wait_until(c0 + 32);

    // auto-repeat held for 40 cycles
    c0 = now; repeat_en[0] = 1'b1; key_raw[0] = 1'b0;
    for (int t = 1; t < 40; t++) begin
      wait_until(c0 + t);
      chk("rep_step", step[0], ((t == 6) || (t >= 16 && (t - 16) % 3 == 0)) ? 1 : 0);
      if (t == 16) chk("rep_model", exp_step[0], 1);
    end
    wait_until(c0 + 40); key_raw[0] = 1'b1;
    wait_until(c0 + 55);

    // reset pulsed while repeating
    c0 = now; key_raw[0] = 1'b0;
    wait_until(c0 + 20); reset = 1'b1;
    wait_until(c0 + 21); reset = 1'b0;
    chk("rst_level", level, 0);
    chk("rst_pulses", press_pulse | release_pulse | step, 0);
    for (int t = 22; t <= 30; t++) begin
      wait_until(c0 + t);
      chk("rst_norel", release_pulse[0], 0);
      chk("rst_press", press_pulse[0], (t == 27) ? 1 : 0);
      chk("rst_step", step[0], (t == 27) ? 1 : 0);
    end
    key_raw[0] = 1'b1; repeat_en[0] = 1'b0;
    wait_until(c0 + 45);

    // key 1 clean, key 2 bouncing
    c0 = now; key_raw[1] = 1'b0; key_raw[2] = 1'b0;
    wait_until(c0 + 2); key_raw[2] = 1'b1;
    wait_until(c0 + 4); key_raw[2] = 1'b0;
    wait_until(c0 + 6);
    chk("b_press1", press_pulse[1], 1); chk("b_press2_early", press_pulse[2], 0);
    key_raw[2] = 1'b1;
    wait_until(c0 + 8); key_raw[2] = 1'b0;
    wait_until(c0 + 13); chk("b_press2_pre", press_pulse[2], 0);
    wait_until(c0 + 14); chk("b_press2", press_pulse[2], 1); chk("b_model2", exp_press[2], 1);
    key_raw[1] = 1'b1; key_raw[2] = 1'b1;
    wait_until(c0 + 26);

    // repeat_en dropped in DELAY at rcnt 5, re-raised 10 cycles later
    c0 = now; repeat_en[0] = 1'b1; key_raw[0] = 1'b0;
    wait_until(c0 + 11); repeat_en[0] = 1'b0;
    wait_until(c0 + 21); repeat_en[0] = 1'b1;
    for (int t = 12; t <= 31; t++) begin
      wait_until(c0 + t);
      chk("held_step", step[0], (t == 31) ? 1 : 0);
    end
    key_raw[0] = 1'b1; repeat_en[0] = 1'b0;
    wait_until(c0 + 45);

    // random activity
    for (int k = 0; k < NK; k++) hold_left[k] = 0;
    repeat (3000) begin
      next_cycle();
      reset = ($urandom_range(0, 399) == 0);
      for (int k = 0; k < NK; k++) begin
        if (hold_left[k] == 0) begin
          key_raw[k]   = 1'($urandom_range(0, 1));
          hold_left[k] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5))
                                                      : int'($urandom_range(5, 40));
        end else begin
          hold_left[k]--;
        end
        if ($urandom_range(0, 29) == 0) repeat_en[k] = ~repeat_en[k];
      end
    end
    reset = 1'b0;
    repeat (5) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
